// File: rtl/turn_sequencer_if.sv
// Turn sequencer bus: player move requests, board/win-checker status in,
// turn grant, board write enables and game status out.
interface turn_sequencer_if #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned MAX_MOVES   = 9
);
    localparam int unsigned PW  = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int unsigned MCW = $clog2(MAX_MOVES + 1);

    logic                   start;
    logic                   new_game;
    logic [NUM_PLAYERS-1:0] play;
    logic                   illegal_move;
    logic                   win;
    logic                   no_space;

    logic [NUM_PLAYERS-1:0] player_turn;
    logic [NUM_PLAYERS-1:0] move_accept;
    logic                   illegal_pulse;
    logic [PW-1:0]          current_player;
    logic [MCW-1:0]         move_count;
    logic                   game_over;
    logic                   winner_valid;
    logic [PW-1:0]          winner;
    logic                   timeout_skip;

    modport slave (
        input  start, new_game, play, illegal_move, win, no_space,
        output player_turn, move_accept, illegal_pulse, current_player,
               move_count, game_over, winner_valid, winner, timeout_skip
    );

    modport master (
        output start, new_game, play, illegal_move, win, no_space,
        input  player_turn, move_accept, illegal_pulse, current_player,
               move_count, game_over, winner_valid, winner, timeout_skip
    );
endinterface

// File: rtl/turn_sequencer.sv
// Round-robin N-player turn/game controller for the XO board datapath.
// Define TURN_TIMEOUT_EN to skip a turn after TIMEOUT_CYCLES idle cycles in WAIT_MOVE.
module turn_sequencer #(
    parameter int unsigned NUM_PLAYERS    = 2,
    parameter int unsigned MAX_MOVES      = 9,
    parameter int unsigned FIRST_PLAYER   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic             clock,
    input  logic             reset_n,
    turn_sequencer_if.slave  bus
);
    localparam int unsigned PW  = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int unsigned MCW = $clog2(MAX_MOVES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MOVE,
        S_ACCEPT,
        S_CHECK,
        S_GAME_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          cur_q, cur_d;
    logic [PW-1:0]          winner_q, winner_d;
    logic [NUM_PLAYERS-1:0] player_turn_q, player_turn_d;
    logic [NUM_PLAYERS-1:0] move_accept_q, move_accept_d;
    logic                   illegal_pulse_q, illegal_pulse_d;
    logic                   game_over_q, game_over_d;
    logic                   winner_valid_q, winner_valid_d;
    logic [MCW-1:0]         move_count_q, move_count_d;

    logic [PW-1:0]          cur_next;
    logic [NUM_PLAYERS-1:0] cur_onehot;
    logic                   cur_req;
    logic                   take;
    logic                   expire;

    function automatic logic [NUM_PLAYERS-1:0] onehot(input logic [PW-1:0] idx);
        onehot = NUM_PLAYERS'(1) << idx;
    endfunction

    always_comb begin
        cur_onehot = onehot(cur_q);
        cur_next   = (cur_q == PW'(NUM_PLAYERS - 1)) ? '0 : cur_q + 1'b1;
        cur_req    = |(bus.play & cur_onehot);
        take       = cur_req && !bus.illegal_move;
    end

    always_comb begin
        state_d         = state_q;
        cur_d           = cur_q;
        winner_d        = winner_q;
        player_turn_d   = player_turn_q;
        move_accept_d   = '0;
        illegal_pulse_d = 1'b0;
        game_over_d     = game_over_q;
        winner_valid_d  = winner_valid_q;
        move_count_d    = move_count_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d        = S_WAIT_MOVE;
                    cur_d          = PW'(FIRST_PLAYER);
                    player_turn_d  = onehot(PW'(FIRST_PLAYER));
                    move_count_d   = '0;
                    game_over_d    = 1'b0;
                    winner_valid_d = 1'b0;
                    winner_d       = '0;
                end
            end
            S_WAIT_MOVE: begin
                if (take) begin
                    state_d       = S_ACCEPT;
                    move_accept_d = cur_onehot;
                    player_turn_d = '0;
                end else begin
                    illegal_pulse_d = cur_req;
                    if (expire) begin
                        cur_d         = cur_next;
                        player_turn_d = onehot(cur_next);
                    end
                end
            end
            S_ACCEPT: begin
                state_d = S_CHECK;
                if (move_count_q != MCW'(MAX_MOVES)) begin
                    move_count_d = move_count_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (bus.win) begin
                    state_d        = S_GAME_DONE;
                    game_over_d    = 1'b1;
                    winner_valid_d = 1'b1;
                    winner_d       = cur_q;
                end else if (bus.no_space || move_count_q == MCW'(MAX_MOVES)) begin
                    state_d     = S_GAME_DONE;
                    game_over_d = 1'b1;
                end else begin
                    state_d       = S_WAIT_MOVE;
                    cur_d         = cur_next;
                    player_turn_d = onehot(cur_next);
                end
            end
            S_GAME_DONE: begin
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything; a write already issued in ACCEPT is left uncounted.
        if (state_q != S_IDLE && bus.new_game) begin
            state_d         = S_IDLE;
            cur_d           = '0;
            winner_d        = '0;
            player_turn_d   = '0;
            move_accept_d   = '0;
            illegal_pulse_d = 1'b0;
            game_over_d     = 1'b0;
            winner_valid_d  = 1'b0;
            move_count_d    = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            cur_q           <= '0;
            winner_q        <= '0;
            player_turn_q   <= '0;
            move_accept_q   <= '0;
            illegal_pulse_q <= 1'b0;
            game_over_q     <= 1'b0;
            winner_valid_q  <= 1'b0;
            move_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            cur_q           <= cur_d;
            winner_q        <= winner_d;
            player_turn_q   <= player_turn_d;
            move_accept_q   <= move_accept_d;
            illegal_pulse_q <= illegal_pulse_d;
            game_over_q     <= game_over_d;
            winner_valid_q  <= winner_valid_d;
            move_count_q    <= move_count_d;
        end
    end

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES) > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_skip_q, timeout_skip_d;

    // Timer restarts on every WAIT_MOVE entry, including re-entry after a skip.
    always_comb begin
        expire         = (state_q == S_WAIT_MOVE) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
        timeout_skip_d = expire && !take && !bus.new_game;
        timer_d        = '0;
        if (state_q == S_WAIT_MOVE && state_d == S_WAIT_MOVE && !expire) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_q        <= '0;
            timeout_skip_q <= 1'b0;
        end else begin
            timer_q        <= timer_d;
            timeout_skip_q <= timeout_skip_d;
        end
    end

    assign bus.timeout_skip = timeout_skip_q;
`else
    assign expire           = 1'b0;
    assign bus.timeout_skip = 1'b0;
`endif

    assign bus.player_turn    = player_turn_q;
    assign bus.move_accept    = move_accept_q;
    assign bus.illegal_pulse  = illegal_pulse_q;
    assign bus.current_player = cur_q;
    assign bus.move_count     = move_count_q;
    assign bus.game_over      = game_over_q;
    assign bus.winner_valid   = winner_valid_q;
    assign bus.winner         = winner_q;
endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: a 2-player and a 3-player instance.
module tb_turn_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clock = ~clock;

    turn_sequencer_if #(.NUM_PLAYERS(2), .MAX_MOVES(9)) b2 ();
    turn_sequencer_if #(.NUM_PLAYERS(3), .MAX_MOVES(9)) b3 ();

    turn_sequencer #(.NUM_PLAYERS(2), .MAX_MOVES(9), .FIRST_PLAYER(0), .TIMEOUT_CYCLES(8))
        u_dut2 (.clock(clock), .reset_n(reset_n), .bus(b2.slave));
    turn_sequencer #(.NUM_PLAYERS(3), .MAX_MOVES(9), .FIRST_PLAYER(0), .TIMEOUT_CYCLES(1000))
        u_dut3 (.clock(clock), .reset_n(reset_n), .bus(b3.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic       saw_skip;
        logic [1:0] p2;
        {b2.start, b2.new_game, b2.play, b2.illegal_move, b2.win, b2.no_space} = '0;
        {b3.start, b3.new_game, b3.play, b3.illegal_move, b3.win, b3.no_space} = '0;
        repeat (2) step();
        check("rst_turn", b2.player_turn, 0);
        check("rst_cur", b2.current_player, 0);
        check("rst_cnt", b2.move_count, 0);
        check("rst_over", b2.game_over, 0);
        reset_n = 1'b1;
        step();

        // 2 players, nine alternating moves, board full on the last
        b2.start = 1'b1;
        step();
        b2.start = 1'b0;
        check("t1_turn0", b2.player_turn, 2'b01);
        for (int i = 0; i < 9; i++) begin
            p2 = 2'b01 << (i % 2);
            b2.play = p2;
            step();
            check("t1_accept", b2.move_accept, p2);
            b2.play = '0;
            if (i == 8) b2.no_space = 1'b1;
            step();
            check("t1_count", b2.move_count, i + 1);
            step();
            if (i < 8) begin
                check("t1_next_turn", b2.player_turn, 2'b01 << ((i + 1) % 2));
                check("t1_next_cur", b2.current_player, (i + 1) % 2);
            end
        end
        b2.no_space = 1'b0;
        check("t1_over", b2.game_over, 1);
        check("t1_wvalid", b2.winner_valid, 0);
        check("t1_count9", b2.move_count, 9);
        check("t1_turn_done", b2.player_turn, 0);
        b2.new_game = 1'b1;
        step();
        b2.new_game = 1'b0;
        check("t1_ng_over", b2.game_over, 0);

        // 3 players, P2 wins on the third move; off-turn request ignored
        b3.start = 1'b1;
        step();
        b3.start = 1'b0;
        b3.play = 3'b010;
        step();
        check("t2_offturn_acc", b3.move_accept, 0);
        check("t2_offturn_turn", b3.player_turn, 3'b001);
        for (int i = 0; i < 3; i++) begin
            b3.play = 3'(1 << i);
            step();
            check("t2_accept", b3.move_accept, 1 << i);
            b3.play = '0;
            if (i == 2) b3.win = 1'b1;
            step();
            step();
            if (i < 2) check("t2_next_turn", b3.player_turn, 1 << (i + 1));
        end
        b3.win = 1'b0;
        check("t2_over", b3.game_over, 1);
        check("t2_wvalid", b3.winner_valid, 1);
        check("t2_winner", b3.winner, 2);
        check("t2_count", b3.move_count, 3);
        b3.start = 1'b1;
        b3.play = 3'b111;
        step();
        b3.start = 1'b0;
        b3.play = '0;
        check("t2_hold_acc", b3.move_accept, 0);
        check("t2_hold_winner", b3.winner, 2);
        check("t2_hold_over", b3.game_over, 1);

        // Illegal attempts held for three cycles, then a legal move
        b2.start = 1'b1;
        step();
        b2.start = 1'b0;
        b2.play = 2'b01;
        b2.illegal_move = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_illegal", b2.illegal_pulse, 1);
            check("t3_no_acc", b2.move_accept, 0);
            check("t3_turn", b2.player_turn, 2'b01);
        end
        b2.illegal_move = 1'b0;
        step();
        check("t3_acc", b2.move_accept, 2'b01);
        check("t3_illegal_end", b2.illegal_pulse, 0);
        b2.play = '0;
        step();
        step();
        check("t3_next_turn", b2.player_turn, 2'b10);

        // Win and board-full together: win takes priority
        b2.play = 2'b10;
        step();
        b2.play = '0;
        b2.win = 1'b1;
        b2.no_space = 1'b1;
        step();
        step();
        b2.win = 1'b0;
        b2.no_space = 1'b0;
        check("t4_wvalid", b2.winner_valid, 1);
        check("t4_winner", b2.winner, 1);
        b2.new_game = 1'b1;
        step();
        b2.new_game = 1'b0;
        check("t4_ng_over", b2.game_over, 0);
        check("t4_ng_wvalid", b2.winner_valid, 0);
        check("t4_ng_winner", b2.winner, 0);
        check("t4_ng_cnt", b2.move_count, 0);
        check("t4_ng_cur", b2.current_player, 0);

        // Abort during ACCEPT: the move is not counted
        b2.start = 1'b1;
        step();
        b2.start = 1'b0;
        b2.play = 2'b01;
        step();
        b2.play = '0;
        b2.new_game = 1'b1;
        step();
        b2.new_game = 1'b0;
        check("t4b_cnt", b2.move_count, 0);
        check("t4b_turn", b2.player_turn, 0);
        step();
        check("t4b_idle_cnt", b2.move_count, 0);

        // Reset asserted during ACCEPT
        b2.start = 1'b1;
        step();
        b2.start = 1'b0;
        b2.play = 2'b01;
        step();
        b2.play = '0;
        check("t5_acc", b2.move_accept, 2'b01);
        reset_n = 1'b0;
        #1;
        check("t5_rst_acc", b2.move_accept, 0);
        check("t5_rst_turn", b2.player_turn, 0);
        check("t5_rst_over3", b3.game_over, 0);
        #1;
        reset_n = 1'b1;
        step();
        b2.start = 1'b1;
        step();
        b2.start = 1'b0;
        check("t5_restart_cur", b2.current_player, 0);
        check("t5_restart_turn", b2.player_turn, 2'b01);
        check("t5_restart_cnt", b2.move_count, 0);

        // Turn timeout (8 cycles in this instance when the feature is built)
`ifdef TURN_TIMEOUT_EN
        repeat (7) step();
        check("t6_pre_skip", b2.timeout_skip, 0);
        check("t6_pre_cur", b2.current_player, 0);
        step();
        check("t6_skip", b2.timeout_skip, 1);
        check("t6_cur", b2.current_player, 1);
        check("t6_turn", b2.player_turn, 2'b10);
        check("t6_cnt", b2.move_count, 0);
        step();
        check("t6_skip_end", b2.timeout_skip, 0);
`else
        saw_skip = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            saw_skip = saw_skip | b2.timeout_skip;
        end
        check("t6_no_skip", saw_skip, 0);
        check("t6_cur", b2.current_player, 0);
        check("t6_turn", b2.player_turn, 2'b01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
